// File: rtl/control_unit.sv
// control_unit -- multi-cycle LC-3 style instruction sequencer.
//
// Sequences FETCH1 -> FETCH2 (memory wait) -> FETCH3 -> DECODE -> EXEC, or
// parks in HALT on an unsupported opcode. All datapath controls are
// combinational from the current state and the IR.
//
// Optional feature macro: LC3_MEM_TIMEOUT_EN
//   defined   : a 4-bit wait counter bounds FETCH2. The 16th consecutive
//               wait cycle sends the controller to HALT with a sticky fault.
//   undefined : FETCH2 waits indefinitely and fault is tied to 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ir[15:0]                 current instruction register contents
//   n, z, p                  datapath condition codes
//   mem_rdy                  memory read data valid this cycle
//   ld_ir/reg/pc/mar/mdr/cc  register load enables
//   gate_alu/pc/marmux/mdr   bus drivers (at most one high)
//   dr, sr1, sr2             register file addresses
//   aluk                     ALU op: 00 NOT, 01 AND, 10 ADD, 11 PASSA
//   a1m_sel, a2m_sel         address adder operand selects
//   pcmux_sel, marmux_sel    PC and MAR source selects
//   mem_en                   memory read request
//   halted, fault            HALT status and memory-timeout flag
//
// state   | meaning
// FETCH1  | MAR <- PC, PC <- PC+1
// FETCH2  | memory read, wait for mem_rdy, MDR <- mem
// FETCH3  | IR <- MDR
// DECODE  | choose EXEC or HALT from the opcode
// EXEC    | execute ADD/AND/NOT/BR/JMP/LEA
// HALT    | absorbing stop state until reset

module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_rdy,
  output logic        ld_ir,
  output logic        ld_reg,
  output logic        ld_pc,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_cc,
  output logic        gate_alu,
  output logic        gate_pc,
  output logic        gate_marmux,
  output logic        gate_mdr,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [1:0]  aluk,
  output logic        a1m_sel,
  output logic [1:0]  a2m_sel,
  output logic [1:0]  pcmux_sel,
  output logic        marmux_sel,
  output logic        mem_en,
  output logic        halted,
  output logic        fault
);

  localparam logic [2:0] S_FETCH1 = 3'd0;
  localparam logic [2:0] S_FETCH2 = 3'd1;
  localparam logic [2:0] S_FETCH3 = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [2:0] state_q, state_d;
  logic [3:0] opcode;
  logic       br_taken;

  // The immediate/register choice (ir[5]) is resolved by the datapath sr2mux.
  logic unused_ir;
  assign unused_ir = ^ir[5:3];

  assign opcode   = ir[15:12];
  assign br_taken = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);

`ifdef LC3_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
`ifdef LC3_MEM_TIMEOUT_EN
    // Counter is only meaningful inside FETCH2; any other state clears it.
    wait_cnt_d  = '0;
    fault_d     = fault_q;
`endif
    ld_ir       = 1'b0;
    ld_reg      = 1'b0;
    ld_pc       = 1'b0;
    ld_mar      = 1'b0;
    ld_mdr      = 1'b0;
    ld_cc       = 1'b0;
    gate_alu    = 1'b0;
    gate_pc     = 1'b0;
    gate_marmux = 1'b0;
    gate_mdr    = 1'b0;
    dr          = 3'd0;
    sr1         = 3'd0;
    sr2         = 3'd0;
    aluk        = 2'b00;
    a1m_sel     = 1'b0;
    a2m_sel     = 2'b00;
    pcmux_sel   = 2'b00;
    marmux_sel  = 1'b0;
    mem_en      = 1'b0;
    halted      = 1'b0;

    case (state_q)
      S_FETCH1: begin
        gate_pc   = 1'b1;
        ld_mar    = 1'b1;
        pcmux_sel = 2'b10;
        ld_pc     = 1'b1;
        state_d   = S_FETCH2;
      end
      S_FETCH2: begin
        mem_en = 1'b1;
        ld_mdr = mem_rdy;
`ifdef LC3_MEM_TIMEOUT_EN
        if (mem_rdy) begin
          state_d = S_FETCH3;
        end else if (wait_cnt_q == 4'd15) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
`else
        if (mem_rdy) state_d = S_FETCH3;
`endif
      end
      S_FETCH3: begin
        gate_mdr = 1'b1;
        ld_ir    = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_LEA: state_d = S_EXEC;
          default:                                       state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH1;
        case (opcode)
          OP_ADD, OP_AND, OP_NOT: begin
            dr       = ir[11:9];
            sr1      = ir[8:6];
            sr2      = ir[2:0];
            aluk     = (opcode == OP_ADD) ? 2'b10 :
                       (opcode == OP_AND) ? 2'b01 : 2'b00;
            gate_alu = 1'b1;
            ld_reg   = 1'b1;
            ld_cc    = 1'b1;
          end
          OP_BR: begin
            // nzp=000 never matches, so it falls through as a NOP.
            if (br_taken) begin
              a1m_sel   = 1'b0;
              a2m_sel   = 2'b10;
              pcmux_sel = 2'b01;
              ld_pc     = 1'b1;
            end
          end
          OP_JMP: begin
            sr1       = ir[8:6];
            a1m_sel   = 1'b1;
            a2m_sel   = 2'b00;
            pcmux_sel = 2'b01;
            ld_pc     = 1'b1;
          end
          OP_LEA: begin
            a1m_sel     = 1'b0;
            a2m_sel     = 2'b10;
            marmux_sel  = 1'b1;
            gate_marmux = 1'b1;
            dr          = ir[11:9];
            ld_reg      = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_FETCH1;
      end
    endcase

    // Hold every control quiet while reset is asserted.
    if (rst) begin
      ld_ir       = 1'b0;
      ld_reg      = 1'b0;
      ld_pc       = 1'b0;
      ld_mar      = 1'b0;
      ld_mdr      = 1'b0;
      ld_cc       = 1'b0;
      gate_alu    = 1'b0;
      gate_pc     = 1'b0;
      gate_marmux = 1'b0;
      gate_mdr    = 1'b0;
      dr          = 3'd0;
      sr1         = 3'd0;
      sr2         = 3'd0;
      aluk        = 2'b00;
      a1m_sel     = 1'b0;
      a2m_sel     = 2'b00;
      pcmux_sel   = 2'b00;
      marmux_sel  = 1'b0;
      mem_en      = 1'b0;
      halted      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH1;
`ifdef LC3_MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
`ifdef LC3_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  logic        mem_rdy = 1'b0;
  logic        ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc;
  logic        gate_alu, gate_pc, gate_marmux, gate_mdr;
  logic [2:0]  dr, sr1, sr2;
  logic [1:0]  aluk, a2m_sel, pcmux_sel;
  logic        a1m_sel, marmux_sel, mem_en, halted, fault;

  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p), .mem_rdy(mem_rdy),
    .ld_ir(ld_ir), .ld_reg(ld_reg), .ld_pc(ld_pc), .ld_mar(ld_mar),
    .ld_mdr(ld_mdr), .ld_cc(ld_cc),
    .gate_alu(gate_alu), .gate_pc(gate_pc), .gate_marmux(gate_marmux),
    .gate_mdr(gate_mdr),
    .dr(dr), .sr1(sr1), .sr2(sr2), .aluk(aluk),
    .a1m_sel(a1m_sel), .a2m_sel(a2m_sel), .pcmux_sel(pcmux_sel),
    .marmux_sel(marmux_sel), .mem_en(mem_en), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  // Field order: {ld_ir,ld_reg,ld_pc,ld_mar,ld_mdr,ld_cc},
  // {gate_alu,gate_pc,gate_marmux,gate_mdr}, dr, sr1, sr2, aluk,
  // a1m_sel, a2m_sel, pcmux_sel, marmux_sel, mem_en, halted, fault
  logic [29:0] outs;
  assign outs = {ld_ir, ld_reg, ld_pc, ld_mar, ld_mdr, ld_cc,
                 gate_alu, gate_pc, gate_marmux, gate_mdr,
                 dr, sr1, sr2, aluk, a1m_sel, a2m_sel, pcmux_sel,
                 marmux_sel, mem_en, halted, fault};

  function automatic logic [29:0] mk(input logic [5:0] ld, input logic [3:0] gt,
                                     input logic [2:0] d, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [1:0] ak,
                                     input logic a1, input logic [1:0] a2,
                                     input logic [1:0] pc, input logic mm,
                                     input logic me, input logic hl, input logic ft);
    return {ld, gt, d, s1, s2, ak, a1, a2, pc, mm, me, hl, ft};
  endfunction

  logic [29:0] v_f1, v_f2r, v_f2w, v_f3, v_dec, v_halt, v_add;

  localparam logic [15:0] IR_ADD  = 16'h1042; // ADD R0,R1,R2
  localparam logic [15:0] IR_AND  = 16'h5725; // AND R3,R4,#5
  localparam logic [15:0] IR_NOT  = 16'h9E3F; // NOT R7,R0
  localparam logic [15:0] IR_BRZ  = 16'h0405; // BRz +5
  localparam logic [15:0] IR_BR0  = 16'h0005; // BR nzp=000
  localparam logic [15:0] IR_JMP  = 16'hC0C0; // JMP R3
  localparam logic [15:0] IR_LEA  = 16'hEA08; // LEA R5,+8
  localparam logic [15:0] IR_TRAP = 16'hF025; // unsupported -> HALT

  // At most one bus driver in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if (!$onehot0({gate_alu, gate_pc, gate_marmux, gate_mdr})) begin
        bad++;
        $display("FAIL gate_onehot t=%0t: gates=%b want at most one high", $time,
                 {gate_alu, gate_pc, gate_marmux, gate_mdr});
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_rdy = 1'b1; ir = IR_ADD;
    adv();
    @(negedge clk);
    total++;
    if (outs !== 30'd0) begin
      bad++; $display("FAIL reset_quiet: got %h want %h", outs, 30'd0);
    end
    adv();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== v_f1) begin
      bad++; $display("FAIL reset_fetch1: got %h want %h", outs, v_f1);
    end
    adv();
  endtask

  task automatic test_add_sequence();
    logic [29:0] exp_t [6];
    exp_t[0] = v_f1; exp_t[1] = v_f2r; exp_t[2] = v_f3;
    exp_t[3] = v_dec; exp_t[4] = v_add; exp_t[5] = v_f1;
    ir = IR_ADD; mem_rdy = 1'b1; {n, z, p} = 3'b000;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (outs !== exp_t[c]) begin
        bad++; $display("FAIL add_cycle%0d: got %h want %h", c + 1, outs, exp_t[c]);
      end
      adv();
    end
  endtask

  task automatic test_exec_ops();
    logic [15:0] ir_t  [7];
    logic [2:0]  nzp_t [7];
    logic [29:0] exp_t [7];
    ir_t[0] = IR_AND; nzp_t[0] = 3'b000;
    exp_t[0] = mk(6'b010001, 4'b1000, 3'd3, 3'd4, 3'd5, 2'b01, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    ir_t[1] = IR_NOT; nzp_t[1] = 3'b000;
    exp_t[1] = mk(6'b010001, 4'b1000, 3'd7, 3'd0, 3'd7, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    ir_t[2] = IR_BRZ; nzp_t[2] = 3'b010;
    exp_t[2] = mk(6'b001000, 4'b0000, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    ir_t[3] = IR_BRZ; nzp_t[3] = 3'b101;
    exp_t[3] = 30'd0;
    ir_t[4] = IR_BR0; nzp_t[4] = 3'b111;
    exp_t[4] = 30'd0;
    ir_t[5] = IR_JMP; nzp_t[5] = 3'b000;
    exp_t[5] = mk(6'b001000, 4'b0000, 3'd0, 3'd3, 3'd0, 2'b00, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    ir_t[6] = IR_LEA; nzp_t[6] = 3'b000;
    exp_t[6] = mk(6'b010000, 4'b0010, 3'd5, 3'd0, 3'd0, 2'b00, 1'b0, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      ir = ir_t[k]; {n, z, p} = nzp_t[k]; mem_rdy = 1'b1;
      do_reset();
      repeat (4) adv();
      @(negedge clk);
      total++;
      if (outs !== exp_t[k]) begin
        bad++; $display("FAIL exec_op%0d ir=%h: got %h want %h", k, ir_t[k], outs, exp_t[k]);
      end
      adv();
      @(negedge clk);
      total++;
      if (outs !== v_f1) begin
        bad++; $display("FAIL exec_op%0d_next: got %h want %h", k, outs, v_f1);
      end
    end
    adv();
  endtask

  task automatic test_wait_states();
    int mem_en_cnt = 0;
    int ld_ir_cnt  = 0;
    int ld_ir_cyc  = 0;
    int exec_cyc   = 0;
    ir = IR_ADD; mem_rdy = 1'b0; {n, z, p} = 3'b000;
    do_reset();
    for (int c = 1; c <= 8; c++) begin
      mem_rdy = (c >= 5);
      @(negedge clk);
      if (mem_en) mem_en_cnt++;
      if (ld_ir) begin ld_ir_cnt++; ld_ir_cyc = c; end
      if (gate_alu) exec_cyc = c;
      adv();
    end
    total++;
    if (mem_en_cnt != 4) begin
      bad++; $display("FAIL wait_mem_en_cycles: got %0d want 4", mem_en_cnt);
    end
    total++;
    if (ld_ir_cnt != 1 || ld_ir_cyc != 6) begin
      bad++; $display("FAIL wait_ld_ir: got count %0d at cycle %0d want 1 at 6", ld_ir_cnt, ld_ir_cyc);
    end
    total++;
    if (exec_cyc != 8) begin
      bad++; $display("FAIL wait_exec_cycle: got %0d want 8", exec_cyc);
    end
    @(negedge clk);
    total++;
    if (outs !== v_f1) begin
      bad++; $display("FAIL wait_next_fetch: got %h want %h", outs, v_f1);
    end
    adv();
  endtask

  task automatic test_halt();
    ir = IR_TRAP; mem_rdy = 1'b1;
    do_reset();
    repeat (4) adv();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (outs !== v_halt) begin
        bad++; $display("FAIL halt_hold%0d: got %h want %h", k, outs, v_halt);
      end
      adv();
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== 30'd0) begin
      bad++; $display("FAIL halt_rst_quiet: got %h want %h", outs, 30'd0);
    end
    adv();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== v_f1) begin
      bad++; $display("FAIL halt_rst_fetch1: got %h want %h", outs, v_f1);
    end
    adv();
  endtask

  task automatic test_reset_mid_wait();
    ir = IR_ADD; mem_rdy = 1'b0;
    do_reset();
    repeat (5) adv();
    @(negedge clk);
    total++;
    if (outs !== v_f2w) begin
      bad++; $display("FAIL midwait_state: got %h want %h", outs, v_f2w);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== 30'd0) begin
      bad++; $display("FAIL midwait_rst_quiet: got %h want %h", outs, 30'd0);
    end
    adv();
    rst = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== v_f1) begin
      bad++; $display("FAIL midwait_fetch1: got %h want %h", outs, v_f1);
    end
    adv();
    @(negedge clk);
    total++;
    if (outs !== v_f2r) begin
      bad++; $display("FAIL midwait_fetch2: got %h want %h", outs, v_f2r);
    end
    adv();
  endtask

  task automatic test_timeout();
    logic [29:0] v_fault;
    v_fault = mk(6'b0, 4'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    ir = IR_ADD; mem_rdy = 1'b0;
    do_reset();
    adv();
`ifdef LC3_MEM_TIMEOUT_EN
    for (int c = 2; c <= 17; c++) begin
      @(negedge clk);
      total++;
      if (outs !== v_f2w) begin
        bad++; $display("FAIL timeout_wait%0d: got %h want %h", c, outs, v_f2w);
      end
      adv();
    end
    for (int c = 18; c <= 19; c++) begin
      @(negedge clk);
      total++;
      if (outs !== v_fault) begin
        bad++; $display("FAIL timeout_halt%0d: got %h want %h", c, outs, v_fault);
      end
      adv();
    end
    // Ready on the 16th wait cycle still wins over the timeout.
    do_reset();
    @(negedge clk);
    total++;
    if (outs !== v_f1) begin
      bad++; $display("FAIL timeout_clear: got %h want %h", outs, v_f1);
    end
    adv();
    repeat (15) adv();
    mem_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== v_f2r) begin
      bad++; $display("FAIL timeout_edge_ready: got %h want %h", outs, v_f2r);
    end
    adv();
    @(negedge clk);
    total++;
    if (outs !== v_f3) begin
      bad++; $display("FAIL timeout_edge_fetch3: got %h want %h", outs, v_f3);
    end
    adv();
`else
    for (int c = 2; c <= 101; c++) begin
      @(negedge clk);
      total++;
      if (outs !== v_f2w) begin
        bad++; $display("FAIL nowait_limit%0d: got %h want %h", c, outs, v_f2w);
      end
      adv();
    end
    if (v_fault[0]) begin
      mem_rdy = 1'b1;
      @(negedge clk);
      total++;
      if (outs !== v_f2r) begin
        bad++; $display("FAIL nowait_release: got %h want %h", outs, v_f2r);
      end
      adv();
    end
`endif
  endtask

  initial begin
    v_f1   = mk(6'b001100, 4'b0100, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    v_f2r  = mk(6'b000010, 4'b0000, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    v_f2w  = mk(6'b000000, 4'b0000, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    v_f3   = mk(6'b100000, 4'b0001, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    v_dec  = 30'd0;
    v_halt = mk(6'b000000, 4'b0000, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    v_add  = mk(6'b010001, 4'b1000, 3'd0, 3'd1, 3'd2, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    test_reset();
    test_add_sequence();
    test_exec_ops();
    test_wait_states();
    test_halt();
    test_reset_mid_wait();
    test_timeout();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
